// File: rtl/mm_addr_decoder_n.sv
// Memory-mapped register decoder: registers one host request per cycle, fans it out
// to NUM_CH register blocks and tracks one outstanding read with timeout handling.
module mm_addr_decoder_n #(
  parameter int          NUM_CH    = 3,
  parameter int          ADDR_W    = 17,
  parameter int          DATA_W    = 64,
  parameter int          SEL_W     = 3,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] UNMAP_PAT = 32'h5555_AAAA,
  parameter logic [31:0] TO_PAT    = 32'hDEAD_0BAD
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     iMM_WR_EN,
  input  logic                     iMM_RD_EN,
  input  logic [ADDR_W-1:0]        iMM_ADDR,
  input  logic [DATA_W-1:0]        iMM_WR_DATA,
  output logic [DATA_W-1:0]        oMM_RD_DATA,
  output logic                     oMM_RD_DATA_V,
  output logic [ADDR_W-1:0]        oCH_ADDR,
  output logic [DATA_W-1:0]        oCH_WR_DATA,
  output logic [NUM_CH-1:0]        oCH_WR_EN,
  output logic [NUM_CH-1:0]        oCH_RD_EN,
  input  logic [NUM_CH*DATA_W-1:0] iCH_RD_DATA,
  input  logic [NUM_CH-1:0]        iCH_RD_DATA_V,
  output logic                     oRD_BUSY,
  output logic [15:0]              oTIMEOUT_CNT,
  output logic [15:0]              oDROP_CNT
);

  localparam logic [SEL_W:0] NUM_CH_EXT = (SEL_W+1)'(NUM_CH);
  localparam logic [15:0]    TO_LAST    = 16'(TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   laddr, raddr;
  logic [DATA_W-1:0]   lwdata;
  logic                lwen, lren;
  logic [SEL_W-1:0]    sel, cur_ch;
  logic                mapped;
  logic [15:0]         timer;
  logic                timer_done;
  logic                ch_valid;
  logic [DATA_W-1:0]   ch_data;

  // Response word: pattern in the top 32 bits, address in the bottom, zeros between.
  function automatic logic [DATA_W-1:0] pack_resp(input logic [31:0] pat,
                                                  input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] word;
    word                 = '0;
    word[DATA_W-1 -: 32] = pat;
    word[ADDR_W-1:0]     = addr;
    return word;
  endfunction

  assign sel         = laddr[ADDR_W-1 -: SEL_W];
  assign mapped      = ({1'b0, sel} < NUM_CH_EXT);
  assign timer_done  = (timer == TO_LAST);
  assign oCH_ADDR    = laddr;
  assign oCH_WR_DATA = lwdata;
  assign oRD_BUSY    = (state == ST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      laddr  <= '0;
      lwdata <= '0;
      lwen   <= 1'b0;
      lren   <= 1'b0;
    end else begin
      laddr  <= iMM_ADDR;
      lwdata <= iMM_WR_DATA;
      lwen   <= iMM_WR_EN;
      lren   <= iMM_RD_EN;
    end
  end

  // Only the channel owning the outstanding read can complete it.
  always_comb begin
    ch_valid  = 1'b0;
    ch_data   = '0;
    oCH_WR_EN = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cur_ch == SEL_W'(c)) begin
        ch_valid = iCH_RD_DATA_V[c];
        ch_data  = iCH_RD_DATA[c*DATA_W +: DATA_W];
      end
      if (sel == SEL_W'(c)) begin
        oCH_WR_EN[c] = lwen;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (lren && mapped) state_nxt = ST_WAIT;
      ST_WAIT: if (ch_valid || timer_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    oCH_RD_EN = '0;
    if (state == ST_IDLE && lren) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (sel == SEL_W'(c)) oCH_RD_EN[c] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_ch        <= '0;
      raddr         <= '0;
      timer         <= '0;
      oMM_RD_DATA   <= '0;
      oMM_RD_DATA_V <= 1'b0;
      oTIMEOUT_CNT  <= '0;
      oDROP_CNT     <= '0;
    end else begin
      oMM_RD_DATA_V <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (lren) begin
            if (mapped) begin
              cur_ch <= sel;
              raddr  <= laddr;
              timer  <= '0;
            end else begin
              oMM_RD_DATA   <= pack_resp(UNMAP_PAT, laddr);
              oMM_RD_DATA_V <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (lren && oDROP_CNT != 16'hFFFF) oDROP_CNT <= oDROP_CNT + 16'd1;
          // A valid on the last allowed cycle beats the timeout.
          if (ch_valid) begin
            oMM_RD_DATA   <= ch_data;
            oMM_RD_DATA_V <= 1'b1;
          end else if (timer_done) begin
            oMM_RD_DATA   <= pack_resp(TO_PAT, raddr);
            oMM_RD_DATA_V <= 1'b1;
            if (oTIMEOUT_CNT != 16'hFFFF) oTIMEOUT_CNT <= oTIMEOUT_CNT + 16'd1;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_addr_decoder_n.sv
// Randomised self-checking bench for mm_addr_decoder_n against a cycle-scheduled
// transaction model (deadlines and response due-cycles).
module tb_mm_addr_decoder_n;

  localparam int NUM_CH  = 3;
  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 64;
  localparam int SEL_W   = 3;
  localparam int TIMEOUT = 4;
  localparam logic [31:0] UNMAP_PAT = 32'h5555_AAAA;
  localparam logic [31:0] TO_PAT    = 32'hDEAD_0BAD;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     iMM_WR_EN = 1'b0;
  logic                     iMM_RD_EN = 1'b0;
  logic [ADDR_W-1:0]        iMM_ADDR = '0;
  logic [DATA_W-1:0]        iMM_WR_DATA = '0;
  logic [DATA_W-1:0]        oMM_RD_DATA;
  logic                     oMM_RD_DATA_V;
  logic [ADDR_W-1:0]        oCH_ADDR;
  logic [DATA_W-1:0]        oCH_WR_DATA;
  logic [NUM_CH-1:0]        oCH_WR_EN;
  logic [NUM_CH-1:0]        oCH_RD_EN;
  logic [NUM_CH*DATA_W-1:0] iCH_RD_DATA = '0;
  logic [NUM_CH-1:0]        iCH_RD_DATA_V = '0;
  logic                     oRD_BUSY;
  logic [15:0]              oTIMEOUT_CNT;
  logic [15:0]              oDROP_CNT;

  mm_addr_decoder_n #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEL_W(SEL_W),
    .TIMEOUT(TIMEOUT), .UNMAP_PAT(UNMAP_PAT), .TO_PAT(TO_PAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .iMM_WR_EN(iMM_WR_EN), .iMM_RD_EN(iMM_RD_EN), .iMM_ADDR(iMM_ADDR),
    .iMM_WR_DATA(iMM_WR_DATA), .oMM_RD_DATA(oMM_RD_DATA), .oMM_RD_DATA_V(oMM_RD_DATA_V),
    .oCH_ADDR(oCH_ADDR), .oCH_WR_DATA(oCH_WR_DATA), .oCH_WR_EN(oCH_WR_EN),
    .oCH_RD_EN(oCH_RD_EN), .iCH_RD_DATA(iCH_RD_DATA), .iCH_RD_DATA_V(iCH_RD_DATA_V),
    .oRD_BUSY(oRD_BUSY), .oTIMEOUT_CNT(oTIMEOUT_CNT), .oDROP_CNT(oDROP_CNT)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: cycle numbers of the outstanding read and of the next response.
  int               cyc = 0;
  bit               pending = 0;
  int               start = 0;
  int               pch = 0;
  logic [ADDR_W-1:0] paddr = '0;
  int               force_cyc = -1;
  int               force_ch = 0;
  int               due = -1;
  logic [63:0]      due_data = '0;
  logic [63:0]      held = '0;
  int               to_cnt = 0;
  int               drop_cnt = 0;
  int               resp_delay_req = 0;
  bit               noise_en = 0;
  logic [NUM_CH-1:0] extra_vld = '0;
  logic [63:0]      chd [NUM_CH];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] resp_word(input logic [31:0] pat, input logic [ADDR_W-1:0] a);
    return (64'(pat) << 32) | 64'(a);
  endfunction

  task automatic tick();
    logic              lat_we, lat_re;
    logic [ADDR_W-1:0] lat_addr;
    logic [63:0]       lat_wdata;
    logic [NUM_CH-1:0] vld;
    logic [63:0]       exp_wr, exp_rd;
    int                s;
    bit                m, waiting;
    @(posedge clk);
    #1;
    cyc++;
    lat_we    = iMM_WR_EN;
    lat_re    = iMM_RD_EN;
    lat_addr  = iMM_ADDR;
    lat_wdata = iMM_WR_DATA;
    s         = int'(lat_addr >> (ADDR_W - SEL_W));
    m         = (s < NUM_CH);
    waiting   = pending && (cyc > start);

    exp_wr = (lat_we && m) ? (64'd1 << s) : 64'd0;
    checkOutput("ch_addr", 64'(oCH_ADDR), 64'(lat_addr));
    checkOutput("ch_wdata", oCH_WR_DATA, lat_wdata);
    checkOutput("ch_wr_en", 64'(oCH_WR_EN), exp_wr);
    checkOutput("busy", 64'(oRD_BUSY), 64'(waiting));
    checkOutput("rd_v", 64'(oMM_RD_DATA_V), 64'(due == cyc));
    if (due == cyc) held = due_data;
    checkOutput("rd_data", oMM_RD_DATA, held);
    checkOutput("to_cnt", 64'(oTIMEOUT_CNT), 64'(to_cnt));
    checkOutput("drop_cnt", 64'(oDROP_CNT), 64'(drop_cnt));

    vld = '0;
    if (noise_en) vld = NUM_CH'($urandom & $urandom & $urandom);
    if (pending) vld[pch] = 1'b0;
    vld = vld | extra_vld;
    if (cyc == force_cyc) vld[force_ch] = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      chd[c] = {$urandom, $urandom};
      iCH_RD_DATA[c*DATA_W +: DATA_W] = chd[c];
    end
    iCH_RD_DATA_V = vld;

    exp_rd = 64'd0;
    if (lat_re) begin
      if (waiting) begin
        if (drop_cnt < 16'hFFFF) drop_cnt++;
      end else if (m) begin
        exp_rd    = 64'd1 << s;
        pending   = 1;
        start     = cyc;
        pch       = s;
        paddr     = lat_addr;
        force_ch  = s;
        force_cyc = cyc + ((resp_delay_req != 0) ? resp_delay_req
                                                 : int'($urandom_range(1, TIMEOUT + 2)));
      end else begin
        due      = cyc + 1;
        due_data = resp_word(UNMAP_PAT, lat_addr);
      end
    end
    checkOutput("ch_rd_en", 64'(oCH_RD_EN), exp_rd);

    if (waiting) begin
      if (vld[pch]) begin
        due      = cyc + 1;
        due_data = chd[pch];
        pending  = 0;
      end else if (cyc == start + TIMEOUT) begin
        due      = cyc + 1;
        due_data = resp_word(TO_PAT, paddr);
        if (to_cnt < 16'hFFFF) to_cnt++;
        pending  = 0;
      end
    end
  endtask

  task automatic applyStimulus(input logic we, input logic re,
                               input logic [ADDR_W-1:0] addr, input logic [63:0] wdata);
    iMM_WR_EN   = we;
    iMM_RD_EN   = re;
    iMM_ADDR    = addr;
    iMM_WR_DATA = wdata;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd_data"}, oMM_RD_DATA, 64'd0);
    checkOutput({tag, "_rd_v"}, 64'(oMM_RD_DATA_V), 64'd0);
    checkOutput({tag, "_ch_addr"}, 64'(oCH_ADDR), 64'd0);
    checkOutput({tag, "_ch_wdata"}, oCH_WR_DATA, 64'd0);
    checkOutput({tag, "_wr_en"}, 64'(oCH_WR_EN), 64'd0);
    checkOutput({tag, "_rd_en"}, 64'(oCH_RD_EN), 64'd0);
    checkOutput({tag, "_busy"}, 64'(oRD_BUSY), 64'd0);
    checkOutput({tag, "_to_cnt"}, 64'(oTIMEOUT_CNT), 64'd0);
    checkOutput({tag, "_drop_cnt"}, 64'(oDROP_CNT), 64'd0);
  endtask

  initial begin
    logic [ADDR_W-1:0] a;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Write to channel 1, then read channel 2 answering two cycles after RD_EN.
    applyStimulus(1'b1, 1'b0, 17'h04010, 64'h1234);
    idle(1);
    resp_delay_req = 2;
    applyStimulus(1'b0, 1'b1, 17'h08000, '0);
    idle(4);
    // Unmapped read.
    applyStimulus(1'b0, 1'b1, 17'h1A5A5, '0);
    idle(3);
    // Silent channel 0 times out; its late valid must be ignored.
    resp_delay_req = TIMEOUT + 2;
    applyStimulus(1'b0, 1'b1, 17'h00020, '0);
    idle(8);
    // Read plus write while waiting, with valids from the other channels.
    resp_delay_req = TIMEOUT + 1;
    applyStimulus(1'b0, 1'b1, 17'h00020, '0);
    extra_vld = 3'b110;
    applyStimulus(1'b1, 1'b1, 17'h08000, 64'hBEEF);
    extra_vld = '0;
    idle(8);
    // Valid exactly on the last allowed WAIT cycle.
    resp_delay_req = TIMEOUT;
    applyStimulus(1'b0, 1'b1, 17'h04000, '0);
    idle(7);

    noise_en       = 1;
    resp_delay_req = 0;
    for (int i = 0; i < 1500; i++) begin
      a = ADDR_W'($urandom);
      if ($urandom_range(0, 3) != 0) a[ADDR_W-1 -: SEL_W] = SEL_W'($urandom_range(0, NUM_CH - 1));
      applyStimulus(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), a, {$urandom, $urandom});
    end
    noise_en = 0;
    idle(10);

    // Reset while a read is outstanding.
    resp_delay_req = TIMEOUT + 2;
    applyStimulus(1'b0, 1'b1, 17'h00020, '0);
    idle(2);
    iCH_RD_DATA_V = '0;
    rst_n = 1'b0;
    #1;
    checkAllZero("midwait_reset");
    pending   = 0;
    due       = -1;
    held      = '0;
    to_cnt    = 0;
    drop_cnt  = 0;
    force_cyc = -1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(TIMEOUT + 3);
    resp_delay_req = 2;
    applyStimulus(1'b0, 1'b1, 17'h08000, '0);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mm_addr_decoder_n.md
# mm_addr_decoder_n

Parametrised memory-mapped register decoder for link-level configuration space. It registers one host request per cycle and fans it out to NUM_CH downstream register blocks selected by the top address bits. It tracks a single outstanding read, returns read data to the host, and synthesises error responses for unmapped addresses and channel read timeouts. It also keeps saturating timeout and dropped-read counters for firmware diagnostics.

## Interface
Parameters:
- NUM_CH, 3: number of downstream channels, 1..8.
- ADDR_W, 17: host/channel address width.
- DATA_W, 64: data width. Must be >= 32+ADDR_W.
- SEL_W, 3: number of top address bits used as the channel index. 2^SEL_W >= NUM_CH.
- TIMEOUT, 255: WAIT cycles allowed before a read is abandoned, 1..65535.
- UNMAP_PAT, 32'h5555_AAAA: upper word returned for unmapped reads.
- TO_PAT, 32'hDEAD_0BAD: upper word returned for timed-out reads.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- iMM_WR_EN  in  1  host write strobe, one cycle per access.
- iMM_RD_EN  in  1  host read strobe, one cycle per access.
- iMM_ADDR  in  ADDR_W  host address.
- iMM_WR_DATA  in  DATA_W  host write data.
- oMM_RD_DATA  out  DATA_W  read response data.
- oMM_RD_DATA_V  out  1  one-cycle response strobe.
- oCH_ADDR  out  ADDR_W  registered address, shared by all channels.
- oCH_WR_DATA  out  DATA_W  registered write data, shared by all channels.
- oCH_WR_EN  out  NUM_CH  per-channel write strobe.
- oCH_RD_EN  out  NUM_CH  per-channel read strobe.
- iCH_RD_DATA  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
- iCH_RD_DATA_V  in  NUM_CH  per-channel read-valid.
- oRD_BUSY  out  1  high while the FSM is in WAIT.
- oTIMEOUT_CNT  out  16  saturating count of timed-out reads.
- oDROP_CNT  out  16  saturating count of discarded reads.

## Operation
- Stage 1 registers iMM_ADDR, iMM_WR_DATA, iMM_WR_EN and iMM_RD_EN into laddr, lwdata, lwen and lren. oCH_ADDR = laddr. oCH_WR_DATA = lwdata.
- Channel select: sel = laddr[ADDR_W-1 -: SEL_W]. The access is mapped if sel < NUM_CH, otherwise unmapped.
- Writes:
  - A mapped write drives oCH_WR_EN[sel] = lwen combinationally. Writes are posted and are forwarded in any FSM state.
  - An unmapped write is silently dropped.
- Read FSM states are IDLE and WAIT.
- IDLE:
  - Mapped read (lren=1): oCH_RD_EN[sel]=1 for one cycle. Latch cur_ch=sel and laddr into raddr. Clear the timer. Go to WAIT.
  - Unmapped read: no oCH_RD_EN. Next cycle respond {UNMAP_PAT, zero pad, laddr}. Stay in IDLE.
- WAIT:
  - Only iCH_RD_DATA_V[cur_ch] is honoured. Valid from any other channel is ignored.
  - Valid seen: register iCH_RD_DATA slice cur_ch into oMM_RD_DATA, pulse oMM_RD_DATA_V next cycle, go to IDLE.
  - Otherwise the timer increments. When the timer reaches TIMEOUT-1 with no valid, respond {TO_PAT, zero pad, raddr}, increment oTIMEOUT_CNT, go to IDLE.
  - A read arriving (lren=1) while in WAIT is discarded: no oCH_RD_EN, no response, oDROP_CNT increments.
- Valid arriving after a timeout, or while in IDLE, is ignored.
- lwen and lren both set: the write is forwarded and the read is handled as above.
- Counters saturate at 16'hFFFF and are cleared only by reset.

## Timing
- Reset values: all outputs are 0. FSM is IDLE, timer is 0, laddr/lwdata/lwen/lren are 0.
- Cycle T: iMM_RD_EN=1. Cycle T+1: lren=1 and oCH_RD_EN[sel] pulses. Cycle T+2 onward: WAIT.
- Channel valid in cycle T+1+k (k>=1) gives oMM_RD_DATA_V in cycle T+2+k. Minimum host read latency is 3 cycles.
- Unmapped read: oMM_RD_DATA_V in cycle T+2.
- Timeout: response strobe TIMEOUT+1 cycles after oCH_RD_EN (TIMEOUT WAIT cycles, then the registered response cycle).
- Write: oCH_WR_EN in cycle T+1.
- Valid on the final timeout cycle: valid wins. Real data is returned and the counter is not incremented.
- oMM_RD_DATA holds its last value when not strobed.
- Reset asserted mid-WAIT: the FSM returns to IDLE immediately and no response is emitted for the pending read.

## Test plan
- NUM_CH=3. Write addr 17'h04010 data 64'h1234 -> oCH_WR_EN=3'b010 in cycle T+1, oCH_ADDR=17'h04010, oCH_WR_DATA=64'h1234.
- Read addr 17'h08000; channel 2 returns 64'hCAFE at T+3 -> oMM_RD_DATA=64'hCAFE with V in T+4, oRD_BUSY low afterwards.
- Read unmapped addr 17'h1A5A5 -> no oCH_RD_EN; T+2 data = 64'h5555_AAAA_0001_A5A5.
- TIMEOUT=4, channel 0 silent on read of 17'h00020 -> response 64'hDEAD_0BAD_0000_0020 5 cycles after oCH_RD_EN; oTIMEOUT_CNT=1. Late valid is ignored.
- Second read and a write issued while in WAIT -> read is dropped (oDROP_CNT=1, no RD_EN); write is forwarded. Valid from a non-selected channel is ignored.
- Assert rst_n low mid-WAIT -> all outputs are 0 and no response is emitted. A read after release completes normally.
